// File: rtl/result_drain.sv
// result_drain: captures an N x N matrix of 32-bit results on a one-cycle
// valid pulse and streams it out row-major over a valid/ready interface.
// A result that arrives while a matrix is still draining is dropped and
// flagged on the sticky o_overflow.
// Optional build macro RESULT_DRAIN_DROPCNT_EN adds an 8-bit saturating
// drop counter on o_dropCount.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no matrix held, o_valid low, waiting for i_validResult
// DRAIN | buffer holds a matrix, presenting element (row,col) on o_data
module result_drain #(
  parameter int N = 4
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic [N-1:0][N-1:0][31:0]  i_c,
  input  logic                       i_validResult,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [31:0]                o_data,
  output logic [$clog2(N)-1:0]       o_row,
  output logic [$clog2(N)-1:0]       o_col,
  output logic                       o_last,
  output logic                       o_busy,
  output logic                       o_overflow,
  input  logic                       i_clrOverflow
`ifdef RESULT_DRAIN_DROPCNT_EN
  ,
  output logic [7:0]                 o_dropCount
`endif
);

  localparam int W = $clog2(N);
  localparam logic [W-1:0] MAX_IDX = W'(N - 1);

  generate
    if (N < 3 || N > 255) begin : g_bad_n
      $error("result_drain: N must be in 3..255");
    end
  endgenerate

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic [N-1:0][N-1:0][31:0]   buf_q, buf_d;
  logic [W-1:0]                row_q, row_d;
  logic [W-1:0]                col_q, col_d;
  logic                        overflow_q, overflow_d;
  logic [7:0]                  drop_cnt_q, drop_cnt_d;

  logic draining;
  logic at_last;
  logic xfer;
  logic last_xfer;
  logic drop;

  assign draining  = (state_q == S_DRAIN);
  assign at_last   = (row_q == MAX_IDX) && (col_q == MAX_IDX);
  assign xfer      = draining && i_ready;
  assign last_xfer = xfer && at_last;
  // A result landing on the final transfer is taken back-to-back, not dropped.
  assign drop      = draining && i_validResult && !last_xfer;

  // Next-state: capture, row-major walk, drop flagging and drop counting.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    row_d      = row_q;
    col_d      = col_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_validResult) begin
          buf_d   = i_c;
          row_d   = '0;
          col_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_xfer) begin
          row_d = '0;
          col_d = '0;
          if (i_validResult) begin
            buf_d = i_c;
          end else begin
            state_d = S_IDLE;
          end
        end else if (xfer) begin
          if (col_q == MAX_IDX) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Set wins over clear so a drop coinciding with a clear is never lost.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (i_clrOverflow) begin
      overflow_d = 1'b0;
    end

    if (i_clrOverflow) begin
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // State, buffer and flag registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      row_q      <= row_d;
      col_q      <= col_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Outputs decode registered state only; i_ready never reaches them.
  always_comb begin
    o_valid    = draining;
    o_busy     = draining;
    o_data     = draining ? buf_q[row_q][col_q] : 32'd0;
    o_row      = row_q;
    o_col      = col_q;
    o_last     = draining && at_last;
    o_overflow = overflow_q;
  end

`ifdef RESULT_DRAIN_DROPCNT_EN
  assign o_dropCount = drop_cnt_q;
`else
  logic unused_drop_cnt;
  assign unused_drop_cnt = ^drop_cnt_q;
`endif

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain (N=4): directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_result_drain;

  localparam int N = 4;

  logic                      i_clk;
  logic                      i_arst_n;
  logic [N-1:0][N-1:0][31:0] i_c;
  logic                      i_validResult;
  logic                      o_valid;
  logic                      i_ready;
  logic [31:0]               o_data;
  logic [1:0]                o_row;
  logic [1:0]                o_col;
  logic                      o_last;
  logic                      o_busy;
  logic                      o_overflow;
  logic                      i_clrOverflow;
`ifdef RESULT_DRAIN_DROPCNT_EN
  logic [7:0]                o_dropCount;
`endif

  result_drain #(.N(N)) dut (
    .i_clk         (i_clk),
    .i_arst_n      (i_arst_n),
    .i_c           (i_c),
    .i_validResult (i_validResult),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_row         (o_row),
    .o_col         (o_col),
    .o_last        (o_last),
    .o_busy        (o_busy),
    .o_overflow    (o_overflow),
    .i_clrOverflow (i_clrOverflow)
`ifdef RESULT_DRAIN_DROPCNT_EN
    ,
    .o_dropCount   (o_dropCount)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] data;
    int          row;
    int          col;
    logic        last;
  } elem_t;

  elem_t                     exp_q[$];
  logic                      m_ovf;
  int                        m_cnt;
  logic [N-1:0][N-1:0][31:0] mat;
  int                        n_vec;
  int                        n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_matrix();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        elem_t e;
        e.data = mat[r][c];
        e.row  = r;
        e.col  = c;
        e.last = (r == N - 1) && (c == N - 1);
        exp_q.push_back(e);
      end
  endtask

  // Behavioural model: the queue holds every element still owed to the consumer.
  task automatic model_update(input logic v, input logic rdy, input logic clr);
    bit xfer;
    bit last_xfer;
    bit drop;
    xfer      = (exp_q.size() > 0) && rdy;
    last_xfer = xfer && (exp_q.size() == 1);
    drop      = v && (exp_q.size() > 0) && !last_xfer;
    if (xfer) void'(exp_q.pop_front());
    if (v && !drop) push_matrix();
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (clr) m_cnt = drop ? 1 : 0;
    else if (drop && m_cnt < 255) m_cnt++;
  endtask

  task automatic check_outputs();
    bit has;
    has = exp_q.size() > 0;
    chk("valid", 32'(o_valid), 32'(has));
    chk("busy", 32'(o_busy), 32'(has));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
`ifdef RESULT_DRAIN_DROPCNT_EN
    chk("dropcount", 32'(o_dropCount), 32'(m_cnt));
`endif
    if (has) begin
      chk("data", o_data, exp_q[0].data);
      chk("row", 32'(o_row), 32'(exp_q[0].row));
      chk("col", 32'(o_col), 32'(exp_q[0].col));
      chk("last", 32'(o_last), 32'(exp_q[0].last));
    end else begin
      chk("data_idle", o_data, 32'd0);
      chk("last_idle", 32'(o_last), 32'd0);
    end
  endtask

  task automatic step(input logic v, input logic rdy, input logic clr);
    i_validResult = v;
    i_ready       = rdy;
    i_clrOverflow = clr;
    i_c           = mat;
    @(posedge i_clk);
    model_update(v, rdy, clr);
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_data"}, o_data, 32'd0);
    chk({tag, "_row"}, 32'(o_row), 32'd0);
    chk({tag, "_col"}, 32'(o_col), 32'd0);
    chk({tag, "_last"}, 32'(o_last), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_ovf"}, 32'(o_overflow), 32'd0);
  endtask

  task automatic set_ramp(input int offset);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = 32'(16 * r + c + offset);
  endtask

  task automatic drain_out(input bit toggle);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      step(1'b0, toggle ? ((k % 2) == 0) : 1'b1, 1'b0);
      k++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
    mat = '0;
    i_arst_n = 1'b0;
    i_c = '0;
    i_validResult = 1'b0;
    i_ready = 1'b0;
    i_clrOverflow = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_values("reset");
    i_arst_n = 1'b1;
    @(negedge i_clk);

    // Full-throughput drain of the ramp matrix.
    set_ramp(0);
    step(1'b1, 1'b1, 1'b0);
    drain_out(1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Alternating backpressure.
    step(1'b1, 1'b0, 1'b0);
    drain_out(1'b1);

    // Drop while draining element 5, then clear.
    step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    set_ramp(500);
    step(1'b1, 1'b1, 1'b0);
    chk("ovf_after_drop", 32'(o_overflow), 32'd1);
    set_ramp(0);
    drain_out(1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("ovf_after_clr", 32'(o_overflow), 32'd0);

    // Back-to-back capture on the last transfer.
    step(1'b1, 1'b1, 1'b0);
    while (exp_q.size() > 1) step(1'b0, 1'b1, 1'b0);
    set_ramp(1000);
    step(1'b1, 1'b1, 1'b0);
    chk("b2b_data", o_data, 32'd1000);
    chk("b2b_busy", 32'(o_busy), 32'd1);
    chk("b2b_ovf", 32'(o_overflow), 32'd0);
    drain_out(1'b0);

    // Asynchronous reset after 7 transfers.
    set_ramp(0);
    step(1'b1, 1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b1, 1'b0);
    #2 i_arst_n = 1'b0;
    #1 check_reset_values("mid_reset");
    exp_q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
    @(negedge i_clk);
    i_arst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("restart_row", 32'(o_row), 32'd0);
    chk("restart_col", 32'(o_col), 32'd0);
    drain_out(1'b0);

    // Clear coinciding with a drop, then saturate the drop counter.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(o_overflow), 32'd1);
    repeat (300) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    drain_out(1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic v;
      v = ($urandom_range(0, 15) == 0);
      if (v)
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            mat[r][c] = $urandom;
      step(v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
